rr_ring_arbiter: RTL

Round-robin arbiter that shares one downstream resource among N requesters. Priority comes from a one-hot rotating ring pointer. The grant is registered and held while the owner keeps requesting, up to a bounded tenure. On release, ownership passes to the next requester with no bubble. It sits in front of any shared datapath, where it sequences access and supplies a one-hot select plus an encoded owner index.

---
 rtl/rr_arb_pkg.sv | 50 +++++
 rtl/rr_ring_ptr.sv | 21 ++
 rtl/rr_ring_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and pure helpers for the round-robin ring arbiter.
// Helpers work on a fixed MAX_N-wide vector so any N up to MAX_N can reuse them.
package rr_arb_pkg;

    localparam int MAX_N = 32;
    localparam int IDX_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set bit of req at or after the one-hot ptr position, wrapping at n-1.
    function automatic logic [MAX_N-1:0] rr_pick(
        input logic [MAX_N-1:0] req,
        input logic [MAX_N-1:0] ptr,
        input int               n
    );
        logic [MAX_N-1:0] win;
        logic             found;
        int               base;
        int               idx;
        win   = '0;
        found = 1'b0;
        base  = 0;
        idx   = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && ptr[IDX_W'(i)]) base = i;
        end
        for (int k = 0; k < MAX_N; k++) begin
            idx = base + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !found && req[IDX_W'(idx)]) begin
                win[IDX_W'(idx)] = 1'b1;
                found            = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [IDX_W-1:0] onehot2bin(input logic [MAX_N-1:0] oh);
        logic [IDX_W-1:0] b;
        b = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[IDX_W'(i)]) b = b | IDX_W'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_ring_ptr.sv
// One-hot priority ring; on load it points one past the releasing owner.
// Holds its value otherwise; no handshake.
module rr_ring_ptr #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_en,
    input  logic [N-1:0] owner,
    output logic [N-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= N'(1);
        end else if (load_en) begin
            ptr <= {owner[N-2:0], owner[N-1]};
        end
    end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with bounded tenure; one-cycle req-to-gnt, zero-bubble handover.
// Owner keeps the grant while requesting, up to MAX_HOLD cycles (0 = unlimited); N <= 32.
module rr_ring_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy
);

    localparam int ID_W  = $clog2(N);
    localparam int CNT_W = (MAX_HOLD == 0) ? 4 : $clog2(MAX_HOLD + 1);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [N-1:0]     ptr;
    logic [N-1:0]     arb_ptr;
    logic [N-1:0]     pick;
    logic [ID_W-1:0]  pick_id;
    logic             expired;
    logic             release_now;

    // On release, arbitrate against the rotated pointer in the same cycle so the
    // handover has no idle gap; the old owner naturally ends up lowest priority.
    always_comb begin
        expired     = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD));
        release_now = (state == GRANT) && (!(|(req & gnt)) || expired);
        arb_ptr     = (state == GRANT) ? {gnt[N-2:0], gnt[N-1]} : ptr;
        pick        = N'(rr_pick(MAX_N'(req), MAX_N'(arb_ptr), N));
        pick_id     = ID_W'(onehot2bin(MAX_N'(pick)));
    end

    rr_ring_ptr #(.N(N)) u_ptr (
        .clk     (clk),
        .reset   (reset),
        .load_en (release_now),
        .owner   (gnt),
        .ptr     (ptr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= GRANT;
                        gnt      <= pick;
                        gnt_id   <= pick_id;
                        busy     <= 1'b1;
                        hold_cnt <= CNT_W'(1);
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        if (|pick) begin
                            gnt      <= pick;
                            gnt_id   <= pick_id;
                            hold_cnt <= CNT_W'(1);
                        end else begin
                            state    <= IDLE;
                            gnt      <= '0;
                            gnt_id   <= '0;
                            busy     <= 1'b0;
                            hold_cnt <= '0;
                        end
                    end else if (hold_cnt != {CNT_W{1'b1}}) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
